// File: rtl/sniffer_wr_buffer.sv
// Write buffer between the sniffer's Wishbone write-only master and RAM port A.
// Capture writes are queued in a small FIFO and drained one word per cycle under ram_ready_i.
module sniffer_wr_buffer #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 14
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [31:0]                s_addr_i,
  input  logic [31:0]                s_data_i,
  input  logic [3:0]                 s_sel_i,
  input  logic                       s_we_i,
  input  logic                       s_stb_i,
  output logic                       s_stall_o,
  output logic                       s_ack_o,
  output logic                       ram_en_o,
  output logic                       ram_we_o,
  output logic [3:0]                 ram_be_o,
  output logic [ADDR_W-1:0]          ram_addr_o,
  output logic [31:0]                ram_data_o,
  input  logic                       ram_ready_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       empty_o,
  output logic [15:0]                stall_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned ENT_W = ADDR_W + 4 + 32;

  typedef enum logic {IDLE, VALID} out_state_t;

  out_state_t         state;
  logic [ENT_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   count;
  logic               full;
  logic               fifo_empty;
  logic               accept;
  logic               push;
  logic               pop;
  logic [ENT_W-1:0]   wr_entry;

  // Address bits outside the RAM word range are intentionally dropped.
  logic               unused_addr_bits;
  assign unused_addr_bits = ^{s_addr_i[31:ADDR_W+2], s_addr_i[1:0]};

  assign full       = (count == LVL_W'(DEPTH));
  assign fifo_empty = (count == '0);
  assign accept     = s_stb_i & ~full;
  assign push       = accept & s_we_i & ~flush_i;
  assign pop        = ~fifo_empty & ~flush_i & ((state == IDLE) | ram_ready_i);
  assign wr_entry   = {s_addr_i[ADDR_W+1:2], s_sel_i, s_data_i};

  assign s_stall_o   = full;
  assign level_o     = count;
  assign ram_en_o    = (state == VALID);
  assign ram_we_o    = ram_en_o;
  assign empty_o     = fifo_empty & (state == IDLE);

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      state       <= IDLE;
      ram_addr_o  <= '0;
      ram_be_o    <= '0;
      ram_data_o  <= '0;
      s_ack_o     <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      // Requests in the flush cycle are still acked; only their data is dropped.
      s_ack_o <= accept;
      if (flush_i) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        count       <= '0;
        state       <= IDLE;
        stall_cnt_o <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
          {ram_addr_o, ram_be_o, ram_data_o} <= mem[rd_ptr];
        end
        case ({push, pop})
          2'b10:   count <= count + LVL_W'(1);
          2'b01:   count <= count - LVL_W'(1);
          default: count <= count;
        endcase
        case (state)
          IDLE:    if (pop) state <= VALID;
          VALID:   if (ram_ready_i && !pop) state <= IDLE;
          default: state <= IDLE;
        endcase
        if (s_stb_i && full && (stall_cnt_o != '1)) begin
          stall_cnt_o <= stall_cnt_o + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sniffer_wr_buffer.sv
// Directed bench for sniffer_wr_buffer: queue-based reference model compared every cycle,
// plus literal expectations for the headline scenarios.
module tb_sniffer_wr_buffer;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [31:0]       s_addr, s_data;
  logic [3:0]        s_sel;
  logic              s_we, s_stb;
  logic              s_stall, s_ack;
  logic              ram_en, ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_data;
  logic              ram_ready;
  logic [3:0]        level;
  logic              empty;
  logic [15:0]       stall_cnt;

  sniffer_wr_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush),
    .s_addr_i(s_addr), .s_data_i(s_data), .s_sel_i(s_sel), .s_we_i(s_we), .s_stb_i(s_stb),
    .s_stall_o(s_stall), .s_ack_o(s_ack),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_be_o(ram_be), .ram_addr_o(ram_addr),
    .ram_data_o(ram_data), .ram_ready_i(ram_ready),
    .level_o(level), .empty_o(empty), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffered words in a queue, one word held at the RAM port.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       data;
  } word_t;

  word_t       mq[$];
  word_t       m_stage;
  logic        m_valid;
  logic        m_ack;
  int unsigned m_stall_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_valid     = 1'b0;
      m_ack       = 1'b0;
      m_stall_cnt = 0;
    end else begin
      bit m_full, m_acc;
      m_full = (mq.size() == DEPTH);
      m_acc  = s_stb && !m_full;
      m_ack  = m_acc;
      if (flush) begin
        mq.delete();
        m_valid     = 1'b0;
        m_stall_cnt = 0;
      end else begin
        if (s_stb && m_full && m_stall_cnt < 65535) m_stall_cnt++;
        if (mq.size() > 0 && (!m_valid || ram_ready)) begin
          m_stage = mq.pop_front();
          m_valid = 1'b1;
        end else if (m_valid && ram_ready) begin
          m_valid = 1'b0;
        end
        if (m_acc && s_we) begin
          word_t w;
          w.addr = s_addr[ADDR_W+1:2];
          w.be   = s_sel;
          w.data = s_data;
          mq.push_back(w);
        end
      end
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("stall", s_stall, mq.size() == DEPTH);
      check("ack", s_ack, m_ack);
      check("ram_en", ram_en, m_valid);
      check("ram_we", ram_we, m_valid);
      check("level", level, mq.size());
      check("empty", empty, (mq.size() == 0) && !m_valid);
      check("stall_cnt", stall_cnt, m_stall_cnt);
      if (m_valid) begin
        check("ram_addr", ram_addr, m_stage.addr);
        check("ram_be", ram_be, m_stage.be);
        check("ram_data", ram_data, m_stage.data);
      end
    end
  end

  bit                mon_en = 1'b0;
  logic [ADDR_W-1:0] got_addr[$];
  always @(negedge clk) begin
    if (mon_en && ram_en && ram_ready) got_addr.push_back(ram_addr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
    s_stb = 1'b1; s_we = 1'b1; s_addr = a; s_data = d; s_sel = sel;
  endtask

  task automatic idle_bus();
    s_stb = 1'b0; s_we = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, s_ack, 1'b0);
    check({tag, "_stall"}, s_stall, 1'b0);
    check({tag, "_ram_en"}, ram_en, 1'b0);
    check({tag, "_ram_addr"}, ram_addr, '0);
    check({tag, "_ram_data"}, ram_data, '0);
    check({tag, "_level"}, level, '0);
    check({tag, "_empty"}, empty, 1'b1);
    check({tag, "_stall_cnt"}, stall_cnt, '0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ram_ready = 1'b0;
    s_addr = '0; s_data = '0; s_sel = '0; s_we = 1'b0; s_stb = 1'b0;
    #1;
    check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;
    step();

    // 1: single write, then an address that exercises the wrap of the word address
    ram_ready = 1'b1;
    set_wr(32'h40, 32'hDEADBEEF, 4'hF);
    step();
    idle_bus();
    check("t1_ack", s_ack, 1'b1);
    check("t1_en_early", ram_en, 1'b0);
    step();
    check("t1_en", ram_en, 1'b1);
    check("t1_addr", ram_addr, 14'h10);
    check("t1_be", ram_be, 4'hF);
    check("t1_data", ram_data, 32'hDEADBEEF);
    set_wr(32'hFFFF_FFFC, 32'h1234_5678, 4'h3);
    step(); idle_bus(); step();
    check("t1_wrap_addr", ram_addr, 14'h3FFF);
    check("t1_wrap_be", ram_be, 4'h3);
    repeat (3) step();

    // 2: fill with RAM blocked, hold a stalled strobe, then release
    ram_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_wr(32'h100 + 32'(4 * i), 32'hA000 + 32'(i), 4'hF);
      step();
    end
    check("t2_level_full", level, 4'd8);
    check("t2_stall", s_stall, 1'b1);
    set_wr(32'h200, 32'hB009, 4'h5);
    repeat (5) step();
    check("t2_stall_cnt", stall_cnt, 16'd5);
    ram_ready = 1'b1;
    step();
    check("t2_unstall", s_stall, 1'b0);
    step();
    idle_bus();
    repeat (12) step();
    check("t2_drained", empty, 1'b1);

    // 3: streaming with the RAM always ready
    got_addr.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      set_wr(32'h2000 + 32'(4 * i), 32'(i) ^ 32'h5A5A_0000, 4'hF);
      step();
      if (s_stall !== 1'b0 || level > 4'd1) check("t3_stream", {s_stall, level}, 5'd1);
    end
    idle_bus();
    repeat (4) step();
    mon_en = 1'b0;
    check("t3_count", got_addr.size(), 100);
    for (int i = 0; i < got_addr.size() && i < 100; i++)
      if (got_addr[i] !== 14'(14'h800 + i)) check("t3_seq", got_addr[i], 14'(14'h800 + i));

    // 4: read strobe is acked but never reaches the RAM
    s_stb = 1'b1; s_we = 1'b0; s_addr = 32'h80;
    step();
    idle_bus();
    check("t4_ack", s_ack, 1'b1);
    check("t4_level", level, 4'd0);
    check("t4_en", ram_en, 1'b0);
    step();
    check("t4_en2", ram_en, 1'b0);

    // 5: flush with words buffered and a write in the same cycle
    ram_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_wr(32'h400 + 32'(4 * i), 32'hC000 + 32'(i), 4'hF);
      step();
    end
    idle_bus();
    step();
    check("t5_level", level, 4'd5);
    set_wr(32'h500, 32'hC0FF_EE00, 4'hF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle_bus();
    check("t5_ack", s_ack, 1'b1);
    check("t5_level0", level, 4'd0);
    check("t5_empty", empty, 1'b1);
    ram_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (ram_en !== 1'b0) check("t5_no_en", ram_en, 1'b0);
    end

    // 6: reset in the middle of a drain
    ram_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_wr(32'h600 + 32'(4 * i), 32'hD000 + 32'(i), 4'hF);
      step();
    end
    idle_bus();
    ram_ready = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("t6");
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t6_no_en", ram_en, 1'b0);
      check("t6_empty", empty, 1'b1);
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
